// File: rtl/conv_pkg.sv
// conv_pkg: width helpers and round/shift/saturate functions shared by the convolution MAC
package conv_pkg;
    localparam int MAXW = 128;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int prodw(input int dw, input int cw);
        return dw + cw;
    endfunction
    function automatic int treew(input int dw, input int cw, input int ntap);
        return prodw(dw, cw) + clog2(ntap);
    endfunction
    function automatic int accw(input int dw, input int cw, input int ntap, input int guard);
        return treew(dw, cw, ntap) + guard;
    endfunction
    function automatic logic signed [MAXW-1:0] rnd(input logic signed [MAXW-1:0] v, input int shift);
        logic signed [MAXW-1:0] half;
        half = shift > 0 ? MAXW'(1) << (shift - 1) : '0;
        return (v + half) >>> shift;
    endfunction
    function automatic logic signed [MAXW-1:0] hi_lim(input int outw);
        logic signed [MAXW-1:0] lo;
        lo = '1;
        lo = lo <<< (outw - 1);
        return ~lo;
    endfunction
    function automatic logic signed [MAXW-1:0] rnd_sat(input logic signed [MAXW-1:0] v, input int shift, input int outw);
        logic signed [MAXW-1:0] r, hi;
        r = rnd(v, shift);
        hi = hi_lim(outw);
        return r > hi ? hi : r < ~hi ? ~hi : r;
    endfunction
    function automatic logic rnd_clip(input logic signed [MAXW-1:0] v, input int shift, input int outw);
        logic signed [MAXW-1:0] r, hi;
        r = rnd(v, shift);
        hi = hi_lim(outw);
        return r > hi || r < ~hi;
    endfunction
endpackage

// File: rtl/conv_add_tree.sv
// conv_add_tree: registered pairwise signed adder tree, one level per stage, with a {last,valid} tag pipeline
module conv_add_tree import conv_pkg::*; #(
    parameter int N = 8,
    parameter int W = 33
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N*W-1:0]            in_i,
    input  logic [1:0]                tag_i,
    output logic [W+clog2(N)-1:0]     sum_o,
    output logic [1:0]                tag_o
);
    localparam int L = clog2(N);
    localparam int OW = W + L;
    for (genvar k = 0; k <= L; k++) begin : lv
        logic [(N >> k)*OW-1:0] q;
        logic [1:0]             t;
        if (k == 0) begin : g_in
            for (genvar i = 0; i < N; i++) begin : g_ext
                assign q[i*OW +: OW] = OW'(signed'(in_i[i*W +: W]));
            end
            assign t = tag_i;
        end else begin : g_add
            always_ff @(posedge clk)
                if (rst) begin
                    q <= '0;
                    t <= '0;
                end else if (en) begin
                    for (int j = 0; j < (N >> k); j++)
                        q[j*OW +: OW] <= lv[k-1].q[2*j*OW +: OW] + lv[k-1].q[(2*j+1)*OW +: OW];
                    t <= lv[k-1].t;
                end
        end
    end
    assign sum_o = lv[L].q;
    assign tag_o = lv[L].t;
endmodule

// File: rtl/conv_mac_nblock.sv
// conv_mac_nblock: pipelined NTAP-tap multiply/accumulate with round, shift, saturate and stalling valid/ready output
module conv_mac_nblock import conv_pkg::*; #(
    parameter int NTAP      = 8,
    parameter int DW        = 16,
    parameter int CW        = 17,
    parameter int OUTW      = 24,
    parameter int SHIFT     = 12,
    parameter int ACC_GUARD = 4
) (
    input  logic                 ACLK,
    input  logic                 ARST,
    input  logic [NTAP*DW-1:0]   din,
    input  logic [NTAP*CW-1:0]   coef,
    input  logic                 dinval,
    input  logic                 dinlast,
    output logic                 dinrdy,
    output logic [OUTW-1:0]      dout,
    output logic                 dout_sat,
    output logic                 doutval,
    input  logic                 doutrdy
);
    localparam int PRODW = prodw(DW, CW);
    localparam int TREEW = treew(DW, CW, NTAP);
    localparam int ACCW  = accw(DW, CW, NTAP, ACC_GUARD);
    logic                    en;
    logic [NTAP*DW-1:0]      din_q;
    logic [NTAP*CW-1:0]      coef_q;
    logic [1:0]              t0_q, t1_q, tr_tag;
    logic [NTAP*PRODW-1:0]   prod_d, prod_q;
    logic [TREEW-1:0]        tr_sum;
    logic signed [ACCW-1:0]  acc_d, acc_q;
    logic [OUTW-1:0]         dout_q;
    logic                    sat_q, val_q;
    assign en     = !val_q || doutrdy;
    assign dinrdy = en && !ARST;
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < NTAP; i++)
            prod_d[i*PRODW +: PRODW] = PRODW'(signed'(din_q[i*DW +: DW])) * PRODW'(signed'(coef_q[i*CW +: CW]));
    end
    always_ff @(posedge ACLK)
        if (ARST) begin
            din_q  <= '0;
            coef_q <= '0;
            t0_q   <= '0;
            prod_q <= '0;
            t1_q   <= '0;
        end else if (en) begin
            din_q  <= din;
            coef_q <= coef;
            t0_q   <= {dinlast, dinval};
            prod_q <= prod_d;
            t1_q   <= t0_q;
        end
    conv_add_tree #(.N(NTAP), .W(PRODW)) u_tree (
        .clk   (ACLK),
        .rst   (ARST),
        .en    (en),
        .in_i  (prod_q),
        .tag_i (t1_q),
        .sum_o (tr_sum),
        .tag_o (tr_tag)
    );
    assign acc_d = acc_q + ACCW'(signed'(tr_sum));
    // a completed packet leaves the accumulator cleared so the next beat starts fresh
    always_ff @(posedge ACLK)
        if (ARST) begin
            acc_q  <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
            val_q  <= 1'b0;
        end else if (en) begin
            val_q <= tr_tag[0] && tr_tag[1];
            if (tr_tag[0])
                acc_q <= tr_tag[1] ? '0 : acc_d;
            if (tr_tag[0] && tr_tag[1]) begin
                dout_q <= OUTW'(rnd_sat(MAXW'(acc_d), SHIFT, OUTW));
                sat_q  <= rnd_clip(MAXW'(acc_d), SHIFT, OUTW);
            end
        end
    assign dout     = dout_q;
    assign dout_sat = sat_q;
    assign doutval  = val_q;
endmodule

// File: doc/conv_mac_nblock.md
Name: conv_mac_nblock

Overview:
Parametrised successor of the fixed 8-tap, 16x17 pipelined multiply/adder-tree convolution block used in the sound IP filter path. Computes the dot product of NTAP signed samples and NTAP signed coefficients per beat. Can accumulate several beats into one output, which allows filters longer than NTAP taps. Output is rounded, shifted and saturated, and uses a valid/ready handshake with full-pipeline backpressure toward the mixer/output FIFO.

Parameters:
NTAP, 8, taps per beat; power of two, 1..64
DW, 16, signed sample width
CW, 17, signed coefficient width
OUTW, 24, signed output width
SHIFT, 12, arithmetic right shift applied after rounding; 0..ACCW-1
ACC_GUARD, 4, accumulator guard bits; a packet carries at most 2^ACC_GUARD beats

Ports:
ACLK  in  1  clock; all logic on rising edge
ARST  in  1  reset, synchronous, active-high
din  in  NTAP*DW  samples; tap i at [i*DW +: DW], signed
coef  in  NTAP*CW  coefficients; tap i at [i*CW +: CW], signed
dinval  in  1  beat valid
dinlast  in  1  last beat of packet; tie to 1 for single-beat operation
dinrdy  out  1  beat accepted when dinval && dinrdy
dout  out  OUTW  rounded, shifted, saturated packet result
dout_sat  out  1  dout was clipped; qualified by doutval
doutval  out  1  result valid
doutrdy  in  1  downstream ready

Behaviour:
- Widths: L = clog2(NTAP); PRODW = DW+CW; TREEW = PRODW+L; ACCW = TREEW+ACC_GUARD. All arithmetic is signed with sign extension at every stage. No intermediate overflow below the accumulator.
- Global enable: en = !doutval || doutrdy. dinrdy = en && !ARST. When en = 0, every pipeline register and valid/last bit holds.
- Stages, each advancing only when en = 1:
  - S0: register din, coef, valid, last on accept. A bubble loads valid = 0; data are don't-care.
  - S1: NTAP products.
  - S2..S(1+L): pairwise adder tree, one level per stage.
  - Final stage: acc_next = acc + tree_sum (sign-extended to ACCW).
    - Valid, non-last beat: acc <= acc_next; output register unchanged.
    - Valid, last beat: dout <= sat(round(acc_next)); doutval <= 1; acc <= 0.
- Rounding: if SHIFT > 0, add 2^(SHIFT-1) and then arithmetic-shift right by SHIFT. Ties round toward +inf.
- Saturation: clip to [-2^(OUTW-1), 2^(OUTW-1)-1]. dout_sat = 1 iff clipped.
- Output handshake: doutval clears on doutval && doutrdy unless a new result loads in the same cycle; in that case it stays 1 with new data. dout and dout_sat are stable while doutval && !doutrdy.
- Latency: accept edge to doutval rising = 2+L cycles (5 for NTAP=8). Throughput is 1 beat/cycle with no stall. Bubbles are not compressed.
- Reset: all data registers 0, valid bits 0, acc 0, doutval 0, dout 0, dout_sat 0. Reset mid-packet discards the partial accumulation and all in-flight beats. The first beat after reset starts a new packet.
- Packets longer than 2^ACC_GUARD beats are not supported. The accumulator wraps; no error flag is raised.
- NTAP = 1: no tree stages; latency 2.

Decomposition:
- Package conv_pkg: clog2 function; PRODW/TREEW/ACCW width functions; rounding/saturation function taking (value, SHIFT, OUTW).
- One sub-module conv_add_tree (parameters N, W): registered pairwise adder tree with per-level enable and a valid bit pipeline.
- Top level holds: input/product registers, accumulator, output stage, handshake.

Test Plan:
- NTAP=8, SHIFT=0, OUTW=40: all din=1000, coef=2000, dinlast=1 -> dout=16000000 exactly 5 cycles after accept, dout_sat=0.
- SHIFT=12, OUTW=24, tap0 only: din=3, coef=683 (2049) -> dout=1. din=1, coef=2047 -> 0. din=-1, coef=2048 (-2048) -> 0. din=-1, coef=2049 -> -1.
- SHIFT=8, OUTW=24: all din=-32768, coef=-65536 (sum 2^34) -> dout=8388607, dout_sat=1. Same inputs with din=+32767 -> dout=-8388608, dout_sat=1.
- SHIFT=0, OUTW=40: 3-beat packet, each beat sums to 100 (dinlast on the 3rd beat) -> exactly one doutval, dout=300. The next single-beat packet with sum 7 -> dout=7 (accumulator cleared).
- Backpressure: stream 6 back-to-back single-beat packets (sums 1..6), hold doutrdy=0 for 4 cycles mid-stream -> dinrdy=0 while stalled, dout held stable, all 6 outputs delivered in order with no loss or duplication.
- Assert ARST for 1 cycle after beat 2 of a 4-beat packet -> doutval=0 the next cycle, no output for the aborted packet. A following 1-beat packet with sum 5 -> dout=5.
